// File: rtl/snoop_bus_arbiter_pkg.sv
// rtl/snoop_bus_arbiter_pkg.sv - shared message layout, codes and states for the snoop bus arbiter
//
// Purpose: message field layout (packed struct), message type codes,
// source indices, arbiter state enum, default timeout and small helpers
// shared by the interface, the per-source FIFO and the arbiter top.
package snoop_pkg;

  localparam int MSG_W           = 11;
  localparam int NUM_SRC         = 4;
  localparam int DEFAULT_TIMEOUT = 15;

  typedef enum logic [1:0] {
    MSG_NONE       = 2'b00,
    MSG_READ_MISS  = 2'b01,
    MSG_INVALIDATE = 2'b10,
    MSG_RESPONSE   = 2'b11
  } msg_type_e;

  typedef enum logic [1:0] {
    SRC_MEM = 2'd0,
    SRC_P1  = 2'd1,
    SRC_P2  = 2'd2,
    SRC_P3  = 2'd3
  } src_e;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_RESP = 1'b1
  } state_e;

  // Bit positions: [10] from_cpu, [9:8] origin, [7] writeback, [6] wb tag,
  // [5:4] message type, [3] tag, [2:0] data.
  typedef struct packed {
    logic       from_cpu;
    logic [1:0] origin;
    logic       writeback;
    logic       wb_tag;
    logic [1:0] mtype;
    logic       tag;
    logic [2:0] data;
  } snoop_msg_t;

  // A bus slot with no writeback and no coherence request carries nothing.
  function automatic logic msg_is_empty(snoop_msg_t m);
    return !m.writeback && (m.mtype == MSG_NONE);
  endfunction

  // Processor candidate 'off' places after 'ptr' in the cyclic order 1,2,3.
  function automatic logic [1:0] rr_cand(logic [1:0] ptr, logic [1:0] off);
    logic [2:0] c;
    c = {1'b0, ptr} + {1'b0, off} + 3'd1;
    if (c > 3'd3) c = c - 3'd3;
    return c[1:0];
  endfunction

endpackage

// File: rtl/snoop_bus_arbiter_if.sv
// rtl/snoop_bus_arbiter_if.sv - source/bus signal bundle for the snoop bus arbiter
//
// Signals:
//   in_msg      four 11-bit source messages, slice i = [11i+10:11i]
//   in_valid    per-source message valid
//   in_ready    per-source accept (transfer on valid & ready)
//   bus_msg     registered broadcast message
//   bus_valid   bus_msg carries a granted message
//   busy        a read miss is outstanding
//   timeout_err one-cycle pulse when an outstanding read miss is abandoned
// Modports: master = message sources / bus observer, slave = arbiter.
interface snoop_bus_arbiter_if;
  import snoop_pkg::*;

  logic [NUM_SRC*MSG_W-1:0] in_msg;
  logic [NUM_SRC-1:0]       in_valid;
  logic [NUM_SRC-1:0]       in_ready;
  logic [MSG_W-1:0]         bus_msg;
  logic                     bus_valid;
  logic                     busy;
  logic                     timeout_err;

  modport master (
    output in_msg, in_valid,
    input  in_ready, bus_msg, bus_valid, busy, timeout_err
  );

  modport slave (
    input  in_msg, in_valid,
    output in_ready, bus_msg, bus_valid, busy, timeout_err
  );

endinterface

// File: rtl/snoop_bus_arbiter_msg_fifo.sv
// rtl/snoop_bus_arbiter_msg_fifo.sv - 2-deep message FIFO used once per bus source
//
// Ports:
//   clock, reset_n  clock and synchronous active-low reset
//   push, push_data write request and message; ignored while full
//   pop             remove the head; ignored while empty
//   head_data       current head message (valid when head_valid)
//   head_valid      FIFO holds at least one message
//   full            FIFO holds two messages
module msg_fifo
  import snoop_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [MSG_W-1:0] push_data,
  input  logic             pop,
  output logic [MSG_W-1:0] head_data,
  output logic             head_valid,
  output logic             full
);

  logic [MSG_W-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       count;
  logic             do_push;
  logic             do_pop;

  // Fullness is judged on the current count, so a push at count 2 is refused
  // even if the head leaves in the same cycle; at count 1 both may happen.
  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data  = mem[rd_ptr];
  assign head_valid = (count != 2'd0);
  assign full       = (count == 2'd2);

endmodule

// File: rtl/snoop_bus_arbiter.sv
// rtl/snoop_bus_arbiter.sv - snoop bus arbiter: per-source queues, priority/round-robin grant, read-miss tracking
//
// Ports:
//   clock    single rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      snoop_bus_arbiter_if.slave: in_msg/in_valid/in_ready from the four
//            sources (0 = memory, 1..3 = processors), registered bus_msg/bus_valid
//            broadcast, busy while a read miss is outstanding, timeout_err pulse
// Parameter:
//   TIMEOUT  last WAIT_RESP timer value before the pending read miss is abandoned
module snoop_bus_arbiter
  import snoop_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                clock,
  input  logic                reset_n,
  snoop_bus_arbiter_if.slave  bus
);

  localparam int TIMER_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  snoop_msg_t [NUM_SRC-1:0] in_msg;
  snoop_msg_t [NUM_SRC-1:0] head;
  logic [NUM_SRC-1:0]       head_valid;
  logic [NUM_SRC-1:0]       fifo_full;
  logic [NUM_SRC-1:0]       push;
  logic [NUM_SRC-1:0]       pop;
  logic [NUM_SRC-1:0]       eligible;

  state_e             state_q, state_d;
  logic [1:0]         pending_q, pending_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         rr_q, rr_d;
  logic               timeout_q, timeout_d;
  logic [MSG_W-1:0]   bus_msg_q;
  logic               bus_valid_q;

  logic               grant_valid;
  logic [1:0]         grant_idx;
  logic [1:0]         cand;
  snoop_msg_t         grant_msg;

  assign in_msg = bus.in_msg;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    // Empty messages are acknowledged through in_ready but never queued.
    assign push[i] = bus.in_valid[i] && !msg_is_empty(in_msg[i]);

    msg_fifo u_fifo (
      .clock      (clock),
      .reset_n    (reset_n),
      .push       (push[i]),
      .push_data  (in_msg[i]),
      .pop        (pop[i]),
      .head_data  (head[i]),
      .head_valid (head_valid[i]),
      .full       (fifo_full[i])
    );

    // While a read miss is outstanding only responses may move; any other
    // head stays put and blocks the messages queued behind it.
    assign eligible[i] = head_valid[i] &&
                         ((state_q == ST_IDLE) || (head[i].mtype == MSG_RESPONSE));
  end

  assign bus.in_ready = ~fifo_full;

  // Grant: memory first, then processors in round-robin order after rr_q.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = SRC_MEM;
    cand        = SRC_MEM;
    if (eligible[SRC_MEM]) begin
      grant_valid = 1'b1;
      grant_idx   = SRC_MEM;
    end else begin
      for (int k = 0; k < 3; k++) begin
        cand = rr_cand(rr_q, 2'(k));
        if (!grant_valid && eligible[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = cand;
        end
      end
    end
    grant_msg = head[grant_idx];
    pop       = '0;
    if (grant_valid) pop[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    timer_d   = timer_q;
    rr_d      = rr_q;
    timeout_d = 1'b0;

    if (grant_valid && (grant_idx != SRC_MEM)) rr_d = grant_idx;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid && (grant_msg.mtype == MSG_READ_MISS)) begin
          state_d   = ST_WAIT_RESP;
          pending_d = grant_msg.origin;
          timer_d   = '0;
        end
      end
      ST_WAIT_RESP: begin
        // A matching response takes precedence over an expiring timer.
        if (grant_valid && (grant_msg.mtype == MSG_RESPONSE) &&
            (grant_msg.origin == pending_q)) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q == TIMER_W'(TIMEOUT)) begin
          state_d   = ST_IDLE;
          timer_d   = '0;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      pending_q   <= 2'd0;
      timer_q     <= '0;
      rr_q        <= SRC_P3;
      timeout_q   <= 1'b0;
      bus_msg_q   <= '0;
      bus_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      timer_q     <= timer_d;
      rr_q        <= rr_d;
      timeout_q   <= timeout_d;
      bus_msg_q   <= grant_valid ? grant_msg : '0;
      bus_valid_q <= grant_valid;
    end
  end

  assign bus.bus_msg     = bus_msg_q;
  assign bus.bus_valid   = bus_valid_q;
  assign bus.busy        = (state_q == ST_WAIT_RESP);
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb/tb_snoop_bus_arbiter.sv - self-checking bench for snoop_bus_arbiter
module tb_snoop_bus_arbiter;
  import snoop_pkg::*;

  localparam int TB_TIMEOUT = 8;

  typedef struct {
    logic [3:0]       vld;
    logic [3:0][10:0] m;
    logic [3:0]       rdy;
    int               n;
    logic [3:0][10:0] o;
  } vec_t;

  logic clock;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;
  logic [10:0] exp_q[$];

  snoop_bus_arbiter_if bus ();

  snoop_bus_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [10:0] mk(logic [1:0] origin, logic [1:0] mtype, logic tag, logic [2:0] data);
    return {1'b0, origin, 1'b0, 1'b0, mtype, tag, data};
  endfunction

  function automatic vec_t mkv(logic [3:0] vld, logic [10:0] m0, logic [10:0] m1, logic [10:0] m2,
                               logic [10:0] m3, int n, logic [10:0] o0, logic [10:0] o1,
                               logic [10:0] o2, logic [10:0] o3);
    vec_t r;
    r.vld = vld;
    r.m[0] = m0; r.m[1] = m1; r.m[2] = m2; r.m[3] = m3;
    r.rdy = 4'hf;
    r.n = n;
    r.o[0] = o0; r.o[1] = o1; r.o[2] = o2; r.o[3] = o3;
    return r;
  endfunction

  task automatic check(input string name, input logic [43:0] act, input logic [43:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge and scored.
  task automatic tick();
    logic [10:0] e;
    @(posedge clock);
    #1;
    if (bus.bus_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_bus_msg actual=%0h required=none", bus.bus_msg);
      end else begin
        e = exp_q.pop_front();
        check("bus_msg", {33'b0, bus.bus_msg}, {33'b0, e});
      end
    end else begin
      check("bus_msg_zero_when_idle", {33'b0, bus.bus_msg}, 44'h0);
    end
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      tick();
      budget--;
    end
    check({name, "_drained"}, 44'(exp_q.size()), 44'h0);
    exp_q.delete();
    tick();
    tick();
  endtask

  task automatic drive(input int src, input logic [10:0] m);
    bus.in_msg[11*src +: 11] = m;
    bus.in_valid[src] = 1'b1;
  endtask

  initial begin
    vec_t vecs[9];
    logic [10:0] i1, i2, i3, a, b, c, r;

    i1 = mk(2'd1, 2'b10, 1'b1, 3'd0);
    i2 = mk(2'd2, 2'b10, 1'b1, 3'd0);
    i3 = mk(2'd3, 2'b10, 1'b1, 3'd0);
    vecs[0] = mkv(4'b1110, 11'h0, i1, i2, i3, 3, i1, i2, i3, 11'h0);
    a = mk(2'd1, 2'b10, 1'b1, 3'd1);
    b = mk(2'd2, 2'b10, 1'b1, 3'd1);
    c = mk(2'd3, 2'b10, 1'b1, 3'd1);
    vecs[1] = mkv(4'b1110, 11'h0, a, b, c, 3, a, b, c, 11'h0);
    r = mk(2'd1, 2'b11, 1'b0, 3'd5);
    a = mk(2'd1, 2'b10, 1'b0, 3'd2);
    vecs[2] = mkv(4'b0011, r, a, 11'h0, 11'h0, 2, r, a, 11'h0, 11'h0);
    vecs[3] = mkv(4'b0100, 11'h0, 11'h0, 11'h0, 11'h0, 0, 11'h0, 11'h0, 11'h0, 11'h0);
    b = mk(2'd2, 2'b00, 1'b0, 3'd7);
    c = mk(2'd3, 2'b10, 1'b0, 3'd3);
    vecs[4] = mkv(4'b1100, 11'h0, 11'h0, b, c, 1, c, 11'h0, 11'h0, 11'h0);
    b = mk(2'd2, 2'b10, 1'b0, 3'd4);
    vecs[5] = mkv(4'b0100, 11'h0, 11'h0, b, 11'h0, 1, b, 11'h0, 11'h0, 11'h0);
    a = mk(2'd1, 2'b10, 1'b0, 3'd5);
    c = mk(2'd3, 2'b10, 1'b0, 3'd5);
    vecs[6] = mkv(4'b1010, 11'h0, a, 11'h0, c, 2, c, a, 11'h0, 11'h0);
    r = mk(2'd0, 2'b10, 1'b0, 3'd7);
    a = mk(2'd1, 2'b10, 1'b0, 3'd6);
    b = mk(2'd2, 2'b10, 1'b0, 3'd6);
    c = mk(2'd3, 2'b10, 1'b0, 3'd6);
    vecs[7] = mkv(4'b1111, r, a, b, c, 4, r, b, c, a);
    c = {1'b0, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 3'b101};
    vecs[8] = mkv(4'b1000, 11'h0, 11'h0, 11'h0, c, 1, c, 11'h0, 11'h0, 11'h0);

    bus.in_msg = '0;
    bus.in_valid = '0;
    reset_n = 1'b0;
    tick();
    tick();
    check("rst_bus_valid", {43'b0, bus.bus_valid}, 44'h0);
    check("rst_bus_msg", {33'b0, bus.bus_msg}, 44'h0);
    check("rst_busy", {43'b0, bus.busy}, 44'h0);
    check("rst_timeout_err", {43'b0, bus.timeout_err}, 44'h0);
    check("rst_in_ready", {40'b0, bus.in_ready}, 44'hf);
    reset_n = 1'b1;

    foreach (vecs[v]) begin
      for (int s = 0; s < 4; s++) bus.in_msg[11*s +: 11] = vecs[v].m[s];
      bus.in_valid = vecs[v].vld;
      check($sformatf("v%0d_in_ready", v), {40'b0, bus.in_ready}, {40'b0, vecs[v].rdy});
      for (int o = 0; o < vecs[v].n; o++) exp_q.push_back(vecs[v].o[o]);
      tick();
      bus.in_valid = '0;
      drain($sformatf("v%0d", v));
    end

    // P2 read miss blocks P1 invalidate; foreign response passes; matching response releases.
    r = mk(2'd2, 2'b01, 1'b0, 3'd0);
    drive(2, r); exp_q.push_back(r);
    tick(); bus.in_valid = '0;
    tick();
    check("rm_on_bus", {43'b0, bus.bus_valid}, 44'h1);
    check("rm_busy", {43'b0, bus.busy}, 44'h1);
    a = mk(2'd1, 2'b10, 1'b1, 3'd4);
    drive(1, a);
    tick(); bus.in_valid = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hol_blocked", {43'b0, bus.bus_valid}, 44'h0);
      check("hol_busy", {43'b0, bus.busy}, 44'h1);
    end
    c = mk(2'd3, 2'b11, 1'b0, 3'd6);
    drive(0, c); exp_q.push_back(c);
    tick(); bus.in_valid = '0;
    tick();
    check("foreign_rsp_on_bus", {43'b0, bus.bus_valid}, 44'h1);
    check("foreign_rsp_busy", {43'b0, bus.busy}, 44'h1);
    r = mk(2'd2, 2'b11, 1'b0, 3'd1);
    drive(0, r); exp_q.push_back(r); exp_q.push_back(a);
    tick(); bus.in_valid = '0;
    tick();
    check("rsp_on_bus", {43'b0, bus.bus_valid}, 44'h1);
    check("rsp_busy_clear", {43'b0, bus.busy}, 44'h0);
    tick();
    check("held_inv_on_bus", {43'b0, bus.bus_valid}, 44'h1);
    drain("rm_seq");

    // P3 read miss with no response times out.
    r = mk(2'd3, 2'b01, 1'b0, 3'd2);
    drive(3, r); exp_q.push_back(r);
    tick(); bus.in_valid = '0;
    tick();
    check("to_busy_start", {43'b0, bus.busy}, 44'h1);
    for (int k = 1; k <= TB_TIMEOUT; k++) begin
      tick();
      check("to_busy_hold", {43'b0, bus.busy}, 44'h1);
      check("to_no_early_err", {43'b0, bus.timeout_err}, 44'h0);
    end
    tick();
    check("to_err_pulse", {43'b0, bus.timeout_err}, 44'h1);
    check("to_busy_clear", {43'b0, bus.busy}, 44'h0);
    tick();
    check("to_err_one_cycle", {43'b0, bus.timeout_err}, 44'h0);
    check("to_busy_stays_clear", {43'b0, bus.busy}, 44'h0);

    // Matching response granted exactly in the timeout cycle wins.
    r = mk(2'd1, 2'b01, 1'b0, 3'd3);
    drive(1, r); exp_q.push_back(r);
    tick(); bus.in_valid = '0;
    tick();
    for (int k = 1; k < TB_TIMEOUT; k++) tick();
    check("race_busy_before", {43'b0, bus.busy}, 44'h1);
    c = mk(2'd1, 2'b11, 1'b0, 3'd4);
    drive(0, c); exp_q.push_back(c);
    tick(); bus.in_valid = '0;
    check("race_busy_at_limit", {43'b0, bus.busy}, 44'h1);
    tick();
    check("race_rsp_on_bus", {43'b0, bus.bus_valid}, 44'h1);
    check("race_busy_clear", {43'b0, bus.busy}, 44'h0);
    check("race_no_err", {43'b0, bus.timeout_err}, 44'h0);
    tick();
    check("race_no_err_late", {43'b0, bus.timeout_err}, 44'h0);
    drain("race");

    // P1 queue fills during WAIT_RESP; third invalidate is refused.
    r = mk(2'd2, 2'b01, 1'b0, 3'd3);
    drive(2, r); exp_q.push_back(r);
    tick(); bus.in_valid = '0;
    tick();
    a = mk(2'd1, 2'b10, 1'b1, 3'd1);
    b = mk(2'd1, 2'b10, 1'b1, 3'd2);
    c = mk(2'd1, 2'b10, 1'b1, 3'd3);
    drive(1, a);
    check("fill_ready_0", {43'b0, bus.in_ready[1]}, 44'h1);
    tick();
    drive(1, b);
    check("fill_ready_1", {43'b0, bus.in_ready[1]}, 44'h1);
    tick();
    drive(1, c);
    check("fill_refuse", {43'b0, bus.in_ready[1]}, 44'h0);
    tick();
    check("fill_refuse_hold", {43'b0, bus.in_ready[1]}, 44'h0);
    tick();
    bus.in_valid = '0;
    r = mk(2'd2, 2'b11, 1'b0, 3'd7);
    drive(0, r); exp_q.push_back(r); exp_q.push_back(a); exp_q.push_back(b);
    tick(); bus.in_valid = '0;
    tick();
    check("fill_rsp_busy_clear", {43'b0, bus.busy}, 44'h0);
    check("fill_still_full", {43'b0, bus.in_ready[1]}, 44'h0);
    tick();
    check("fill_released", {43'b0, bus.in_ready[1]}, 44'h1);
    drain("fill");

    // Reset during WAIT_RESP drops pending state and queued messages.
    r = mk(2'd1, 2'b01, 1'b0, 3'd5);
    drive(1, r); exp_q.push_back(r);
    tick(); bus.in_valid = '0;
    tick();
    check("mid_busy", {43'b0, bus.busy}, 44'h1);
    drive(2, mk(2'd2, 2'b10, 1'b0, 3'd1));
    drive(3, mk(2'd3, 2'b10, 1'b0, 3'd1));
    tick(); bus.in_valid = '0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    check("mid_rst_busy", {43'b0, bus.busy}, 44'h0);
    check("mid_rst_in_ready", {40'b0, bus.in_ready}, 44'hf);
    for (int k = 0; k < 3; k++) tick();
    a = mk(2'd1, 2'b10, 1'b0, 3'd2);
    c = mk(2'd3, 2'b10, 1'b0, 3'd2);
    drive(1, a); drive(3, c);
    exp_q.push_back(a); exp_q.push_back(c);
    tick(); bus.in_valid = '0;
    tick();
    check("post_rst_flow", {43'b0, bus.bus_valid}, 44'h1);
    drain("post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
